// File: rtl/sc_io_pkg.sv
// Purpose: shared register offsets, control-bit positions and field layout for the sc_io_bus IO window.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_io_pkg;

    // Word offsets inside the 32-byte IO window (addr[4:2]).
    typedef enum logic [2:0] {
        OFF_SW     = 3'd0,
        OFF_KEY    = 3'd1,
        OFF_LED    = 3'd2,
        OFF_HEX    = 3'd3,
        OFF_TCTRL  = 3'd4,
        OFF_TCOUNT = 3'd5,
        OFF_TCMP   = 3'd6,
        OFF_TSTAT  = 3'd7
    } io_off_e;

    // TCTRL bit positions.
    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_RELOAD = 1;

    // KEY register layout: flags in the low nibble, live levels in the next nibble.
    localparam int KEY_FLAG_LSB  = 0;
    localparam int KEY_LEVEL_LSB = 4;
    localparam int KEY_FIELD_W   = 4;

    // TSTAT bit position of the match flag.
    localparam int TSTAT_MATCH = 0;

    typedef struct packed {
        logic reload;
        logic en;
    } tctrl_t;

    // Read-back image of the timer control register.
    function automatic logic [31:0] tctrl_word(input tctrl_t c);
        logic [31:0] w;
        w = '0;
        w[TCTRL_EN]     = c.en;
        w[TCTRL_RELOAD] = c.reload;
        return w;
    endfunction

endpackage

// File: rtl/sc_io_bus_if.sv
// Purpose: data-side bus between core/RAM and the IO decode stage.
// Latency: n/a (wires only).
// Backpressure: none; the single-cycle core never stalls.
// Signals: addr/wdata/wmem from core, ram_rdata from data RAM,
//          rdata back to core, ram_we to data RAM.
interface sc_io_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;
    logic [31:0] ram_rdata;
    logic        ram_we;

    // Core + data RAM side.
    modport master (
        output addr, wdata, wmem, ram_rdata,
        input  rdata, ram_we
    );

    // IO bus stage side.
    modport slave (
        input  addr, wdata, wmem, ram_rdata,
        output rdata, ram_we
    );
endinterface

// File: rtl/sc_io_timer.sv
// Purpose: prescaled 32-bit timer with compare, reload/one-shot modes and sticky match flag.
// Latency: register writes visible one edge after the store; match one edge after the compare tick.
// Backpressure: none; write strobes are accepted every cycle.
// Ports: clock/resetn; ctrl/count/cmp/stat write strobes + wdata_i;
//        count_o, cmp_o, ctrl_o, match_o.
module sc_io_timer
    import sc_io_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ctrl_we_i,
    input  logic        count_we_i,
    input  logic        cmp_we_i,
    input  logic        stat_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] cmp_o,
    output tctrl_t      ctrl_o,
    output logic        match_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_q, pre_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    tctrl_t      ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic        tick;
    logic        hit;

    always_comb begin
        tick = ctrl_q.en && (pre_q == PRE_LAST);
        // A TCOUNT write on a tick edge swallows the tick entirely,
        // including its compare.
        hit  = tick && !count_we_i && (count_q == cmp_q);

        pre_d = pre_q;
        if (ctrl_q.en) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end
        if (count_we_i) begin
            pre_d = 16'd0;
        end

        count_d = count_q;
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick) begin
            if (count_q == cmp_q) begin
                if (ctrl_q.reload) begin
                    count_d = 32'd0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        cmp_d = cmp_we_i ? wdata_i : cmp_q;

        // One-shot mode stops itself on match; an explicit TCTRL store on
        // the same edge takes precedence since software asked for it last.
        ctrl_d = ctrl_q;
        if (hit && !ctrl_q.reload) begin
            ctrl_d.en = 1'b0;
        end
        if (ctrl_we_i) begin
            ctrl_d.en     = wdata_i[TCTRL_EN];
            ctrl_d.reload = wdata_i[TCTRL_RELOAD];
        end

        // Set beats W1C so a match landing on the clear edge is not lost.
        match_d = hit | (match_q & ~(stat_we_i & wdata_i[TSTAT_MATCH]));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre_q   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
        end
    end

    assign count_o = count_q;
    assign cmp_o   = cmp_q;
    assign ctrl_o  = ctrl_q;
    assign match_o = match_q;

endmodule

// File: rtl/sc_io_bus.sv
// Purpose: data-side bus stage: decodes a 32-byte IO window (switches, keys, LED, hex, timer), passes the rest to RAM.
// Latency: reads combinational (0 cycles); writes land one edge after the store; key flag 3 edges after a press.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: clock/resetn; bus (slave modport: addr, wdata, wmem, ram_rdata -> rdata, ram_we);
//        sw_in/key_in async inputs; led_out, hex_out, timer_irq outputs.
module sc_io_bus
    import sc_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = 32'h0000_0080,
    parameter int          PRESCALE = 50,
    parameter int          SW_W     = 10,
    parameter int          KEY_W    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    sc_io_bus_if.slave       bus,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_in,
    output logic [SW_W-1:0]  led_out,
    output logic [23:0]      hex_out,
    output logic             timer_irq
);

    logic             io_sel;
    logic             io_we;
    io_off_e          off;
    logic [31:0]      io_word;

    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [KEY_W-1:0] key_s1_q, key_s2_q, key_s3_q;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_rise;
    logic [KEY_W-1:0] key_clr;
    logic [KEY_W-1:0] key_flag_q, key_flag_d;
    logic [SW_W-1:0]  led_q, led_d;
    logic [23:0]      hex_q, hex_d;

    logic [31:0]      t_count;
    logic [31:0]      t_cmp;
    tctrl_t           t_ctrl;
    logic             t_match;

    // Byte lane select bits are meaningless for this word-only window.
    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign io_sel = (bus.addr[31:5] == IO_BASE[31:5]);
    assign off    = io_off_e'(bus.addr[4:2]);
    assign io_we  = bus.wmem & io_sel;

    assign bus.ram_we = bus.wmem & ~io_sel;
    assign bus.rdata  = io_sel ? io_word : bus.ram_rdata;

    // Buttons are active-low: a press is the synced level going 1 -> 0,
    // seen by comparing the second sync stage with the one after it.
    assign key_level = ~key_s2_q;
    assign key_rise  = key_s3_q & ~key_s2_q;

    always_comb begin
        key_clr = '0;
        if (io_we && off == OFF_KEY) begin
            key_clr = bus.wdata[KEY_FLAG_LSB +: KEY_W];
        end
        key_flag_d = key_rise | (key_flag_q & ~key_clr);

        led_d = led_q;
        if (io_we && off == OFF_LED) begin
            led_d = bus.wdata[SW_W-1:0];
        end

        hex_d = hex_q;
        if (io_we && off == OFF_HEX) begin
            hex_d = bus.wdata[23:0];
        end
    end

    always_comb begin
        io_word = '0;
        case (off)
            OFF_SW: io_word = 32'(sw_s2_q);
            OFF_KEY: begin
                io_word[KEY_FLAG_LSB  +: KEY_W] = key_flag_q;
                io_word[KEY_LEVEL_LSB +: KEY_W] = key_level;
            end
            OFF_LED:    io_word = 32'(led_q);
            OFF_HEX:    io_word = {8'h00, hex_q};
            OFF_TCTRL:  io_word = tctrl_word(t_ctrl);
            OFF_TCOUNT: io_word = t_count;
            OFF_TCMP:   io_word = t_cmp;
            OFF_TSTAT:  io_word[TSTAT_MATCH] = t_match;
            default:    io_word = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            key_s3_q   <= '0;
            key_flag_q <= '0;
            led_q      <= '0;
            hex_q      <= '0;
        end else begin
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            key_s1_q   <= key_in;
            key_s2_q   <= key_s1_q;
            key_s3_q   <= key_s2_q;
            key_flag_q <= key_flag_d;
            led_q      <= led_d;
            hex_q      <= hex_d;
        end
    end

    sc_io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .ctrl_we_i  (io_we && off == OFF_TCTRL),
        .count_we_i (io_we && off == OFF_TCOUNT),
        .cmp_we_i   (io_we && off == OFF_TCMP),
        .stat_we_i  (io_we && off == OFF_TSTAT),
        .wdata_i    (bus.wdata),
        .count_o    (t_count),
        .cmp_o      (t_cmp),
        .ctrl_o     (t_ctrl),
        .match_o    (t_match)
    );

    assign led_out   = led_q;
    assign hex_out   = hex_q;
    assign timer_irq = t_match;

endmodule

// File: tb/tb_sc_io_bus.sv
module tb_sc_io_bus;

    localparam int SW_W  = 10;
    localparam int KEY_W = 4;
    localparam int NVEC  = 15;

    logic             clock = 1'b0;
    logic             resetn;
    logic [SW_W-1:0]  sw_in;
    logic [KEY_W-1:0] key_in;
    logic [SW_W-1:0]  led_out;
    logic [23:0]      hex_out;
    logic             timer_irq;

    always #5 clock = ~clock;

    sc_io_bus_if bus_if();

    sc_io_bus #(
        .IO_BASE  (32'h0000_0080),
        .PRESCALE (4),
        .SW_W     (SW_W),
        .KEY_W    (KEY_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus_if),
        .sw_in     (sw_in),
        .key_in    (key_in),
        .led_out   (led_out),
        .hex_out   (hex_out),
        .timer_irq (timer_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        sel_we;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wmem;
        logic [31:0] ram_rdata;
        logic [31:0] exp_rdata;
        logic        exp_we;
        string       name;
    } vec_t;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wmem  = 1'b1;
        tick(1);
        bus_if.wmem  = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        bus_if.wmem = 1'b0;
        #1;
        check(name, bus_if.rdata, exp);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0088, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, "led_rst"};
        vecs[1]  = '{32'h0000_008C, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, "hex_rst"};
        vecs[2]  = '{32'h0000_009C, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, "tstat_rst"};
        vecs[3]  = '{32'h0000_0088, 32'h0000_03FF, 1'b1, 32'h0,         32'h0,         1'b0, "led_wr"};
        vecs[4]  = '{32'h0000_0088, 32'h0,         1'b0, 32'h0,         32'h0000_03FF, 1'b0, "led_rd"};
        vecs[5]  = '{32'h0000_0040, 32'h5,         1'b1, 32'h0,         32'h0,         1'b1, "ram_wr"};
        vecs[6]  = '{32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "ram_rd"};
        vecs[7]  = '{32'h0000_008C, 32'hFFAB_CDEF, 1'b1, 32'h0,         32'h0,         1'b0, "hex_wr"};
        vecs[8]  = '{32'h0000_008C, 32'h0,         1'b0, 32'h0,         32'h00AB_CDEF, 1'b0, "hex_rd"};
        vecs[9]  = '{32'h0000_0080, 32'h0,         1'b0, 32'h0,         32'h0000_02A5, 1'b0, "sw_rd"};
        vecs[10] = '{32'h0001_0088, 32'h0,         1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, "alias_wr"};
        vecs[11] = '{32'h0000_008B, 32'h0,         1'b0, 32'h0,         32'h0000_03FF, 1'b0, "led_unaligned"};
        vecs[12] = '{32'h0000_00A0, 32'h0,         1'b0, 32'h0000_0055, 32'h0000_0055, 1'b0, "win_above"};
        vecs[13] = '{32'h0000_007C, 32'h0,         1'b0, 32'h0000_0066, 32'h0000_0066, 1'b0, "win_below"};
        vecs[14] = '{32'h0000_0090, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, "tctrl_rst"};

        // Reset: combinational paths stay live while resetn is low.
        resetn           = 1'b0;
        sw_in            = 10'h2A5;
        key_in           = '1;
        bus_if.addr      = 32'h0000_0040;
        bus_if.wdata     = 32'h0;
        bus_if.wmem      = 1'b1;
        bus_if.ram_rdata = 32'h0000_0011;
        #2;
        check("rst_ram_we", 32'(bus_if.ram_we), 32'h1);
        check("rst_rdata_ram", bus_if.rdata, 32'h0000_0011);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_led", 32'(led_out), 32'h0);
        bus_if.wmem = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(4);

        // Vector table through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            bus_if.addr      = vecs[i].addr;
            bus_if.wdata     = vecs[i].wdata;
            bus_if.wmem      = vecs[i].wmem;
            bus_if.ram_rdata = vecs[i].ram_rdata;
            sb_q.push_back('{{vecs[i].name, "_rdata"}, 1'b0, vecs[i].exp_rdata});
            sb_q.push_back('{{vecs[i].name, "_ram_we"}, 1'b1, 32'(vecs[i].exp_we)});
            @(negedge clock);
            while (sb_q.size() > 0) begin
                sb_t e;
                e = sb_q.pop_front();
                check(e.name, e.sel_we ? 32'(bus_if.ram_we) : bus_if.rdata, e.exp);
            end
            @(posedge clock);
            #1;
        end
        bus_if.wmem = 1'b0;
        check("led_out_pin", 32'(led_out), 32'h0000_03FF);
        check("hex_out_pin", 32'(hex_out), 32'h00AB_CDEF);

        // Key edge capture.
        key_in[2] = 1'b0;
        tick(2);
        chk_rd("key_lvl_e2", 32'h84, 32'h40);
        tick(1);
        chk_rd("key_flag_e3", 32'h84, 32'h44);
        store(32'h84, 32'h4);
        chk_rd("key_w1c", 32'h84, 32'h40);
        tick(5);
        chk_rd("key_hold", 32'h84, 32'h40);
        key_in[2] = 1'b1;
        tick(4);
        chk_rd("key_release", 32'h84, 32'h00);
        key_in[2] = 1'b0;
        tick(3);
        chk_rd("key_repress", 32'h84, 32'h44);
        key_in[2] = 1'b1;
        store(32'h84, 32'hF);
        tick(3);
        chk_rd("key_clr", 32'h84, 32'h00);

        // Reload timer: match every 16 clocks with PRESCALE=4, cmp=3.
        store(32'h98, 32'd3);
        store(32'h90, 32'h3);
        tick(15);
        check("tmr_pre16", 32'(timer_irq), 32'h0);
        tick(1);
        check("tmr_match16", 32'(timer_irq), 32'h1);
        chk_rd("tmr_cnt_reload", 32'h94, 32'h0);
        chk_rd("tstat_set", 32'h9C, 32'h1);
        chk_rd("tctrl_still_en", 32'h90, 32'h3);
        store(32'h9C, 32'h1);
        check("tstat_w1c", 32'(timer_irq), 32'h0);
        tick(14);
        check("tmr_pre32", 32'(timer_irq), 32'h0);
        tick(1);
        check("tmr_match32", 32'(timer_irq), 32'h1);
        store(32'h90, 32'h0);
        store(32'h9C, 32'h1);

        // One-shot timer: cmp=2, stops with count held.
        store(32'h94, 32'h0);
        store(32'h98, 32'd2);
        store(32'h90, 32'h1);
        tick(11);
        check("os_pre12", 32'(timer_irq), 32'h0);
        tick(1);
        check("os_match12", 32'(timer_irq), 32'h1);
        chk_rd("os_en_clr", 32'h90, 32'h0);
        chk_rd("os_cnt_hold", 32'h94, 32'd2);
        tick(10);
        chk_rd("os_cnt_frozen", 32'h94, 32'd2);

        // Asynchronous reset in the middle of counting (match still set).
        store(32'h98, 32'd100);
        store(32'h90, 32'h1);
        tick(13);
        chk_rd("rst_cnt_pre", 32'h94, 32'd5);
        check("rst_irq_pre", 32'(timer_irq), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk_rd("rst_cnt_async", 32'h94, 32'h0);
        chk_rd("rst_en_async", 32'h90, 32'h0);
        check("rst_irq_async", 32'(timer_irq), 32'h0);
        check("rst_led_async", 32'(led_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
